// File: rtl/lift_pkg.sv
// Shared types for the lift car controller.
// Optional emergency stop is enabled by defining LIFT_ESTOP_EN.
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DN,
    DOOR
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    UP,
    DN
  } dir_t;

  function automatic int fw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lift_tick_timer.sv
// Slowref-gated tick counter with clear and terminal-count compare.
// Saturates at the terminal count until cleared.
module lift_tick_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] term,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt < term)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == term);

endmodule

// File: rtl/lift_car_ctrl.sv
// SCAN lift car controller: travel/dwell FSM, floor register, call clears.
// Define LIFT_ESTOP_EN to add the level-sensitive estop freeze input.
module lift_car_ctrl
  import lift_pkg::*;
#(
  parameter int  NFLOORS      = 4,
  parameter int  TRAVEL_TICKS = 8,
  parameter int  DOOR_TICKS   = 4,
  localparam int FW           = fw(NFLOORS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               slowref,
`ifdef LIFT_ESTOP_EN
  input  logic               estop,
`endif
  input  logic [NFLOORS-1:0] requp,
  input  logic [NFLOORS-1:0] reqdn,
  output logic [NFLOORS-1:0] clrup,
  output logic [NFLOORS-1:0] clrdn,
  output logic               upsig,
  output logic               dnsig,
  output logic               moving,
  output logic               door_open,
  output logic [FW-1:0]      floor
);

  localparam int TMAX =
    (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [FW-1:0] TOP = FW'(NFLOORS - 1);
  localparam logic [FW-1:0] BOT = '0;

  state_t state, ns;
  dir_t   dir, nd;

  logic [FW-1:0]      nf, fu, fd;
  logic [NFLOORS-1:0] ra;
  logic [TW-1:0]      term;
  logic               frz, tclr, done;
  logic               anyreq, here, abv, blw;
  logic               abv_u, blw_d, stop_up, stop_dn;
  logic               go_up, go_dn;
  logic               up_ok, dn_ok, wu, wd, pu, pd;

`ifdef LIFT_ESTOP_EN
  assign frz = estop;
`else
  assign frz = 1'b0;
`endif

  function automatic logic any_above(
    input logic [NFLOORS-1:0] r,
    input logic [FW-1:0]      f
  );
    logic [NFLOORS-1:0] m;
    for (int i = 0; i < NFLOORS; i++) m[i] = (i > int'(f));
    return |(r & m);
  endfunction

  function automatic logic any_below(
    input logic [NFLOORS-1:0] r,
    input logic [FW-1:0]      f
  );
    logic [NFLOORS-1:0] m;
    for (int i = 0; i < NFLOORS; i++) m[i] = (i < int'(f));
    return |(r & m);
  endfunction

  assign ra     = requp | reqdn;
  assign anyreq = |ra;
  assign here   = ra[floor];
  assign abv    = any_above(ra, floor);
  assign blw    = any_below(ra, floor);

  // Arrival floor saturates so the ends force a stop.
  assign fu = (floor == TOP) ? floor : floor + 1'b1;
  assign fd = (floor == BOT) ? floor : floor - 1'b1;

  assign abv_u = any_above(ra, fu);
  assign blw_d = any_below(ra, fd);

  assign stop_up = requp[fu] | (fu == TOP) | (!abv_u & reqdn[fu]);
  assign stop_dn = reqdn[fd] | (fd == BOT) | (!blw_d & requp[fd]);

  assign go_up = (dir == DN) ? (!blw & abv) : abv;
  assign go_dn = (dir == DN) ? blw : (!abv & blw);

  assign term = (state == DOOR) ? TW'(DOOR_TICKS) : TW'(TRAVEL_TICKS);

  lift_tick_timer #(
    .CW (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (slowref & ~frz),
    .clr   (tclr & ~frz),
    .term  (term),
    .done  (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dir   <= NONE;
      floor <= '0;
    end else if (!frz) begin
      state <= ns;
      dir   <= nd;
      floor <= nf;
    end
  end

  always_comb begin
    ns   = state;
    nd   = dir;
    nf   = floor;
    tclr = 1'b0;
    unique case (state)
      IDLE: begin
        if (here) begin
          ns = DOOR;
        end else if (abv) begin
          ns = MOVE_UP;
          nd = UP;
        end else if (blw) begin
          ns = MOVE_DN;
          nd = DN;
        end else begin
          nd = NONE;
        end
      end
      MOVE_UP: begin
        if (done) begin
          nf = fu;
          if (!anyreq) begin
            ns = IDLE;
            nd = NONE;
          end else if (stop_up) begin
            ns = DOOR;
          end else begin
            tclr = 1'b1;
          end
        end
      end
      MOVE_DN: begin
        if (done) begin
          nf = fd;
          if (!anyreq) begin
            ns = IDLE;
            nd = NONE;
          end else if (stop_dn) begin
            ns = DOOR;
          end else begin
            tclr = 1'b1;
          end
        end
      end
      DOOR: begin
        if (done) begin
          if (go_up) begin
            ns = MOVE_UP;
            nd = UP;
          end else if (go_dn) begin
            ns = MOVE_DN;
            nd = DN;
          end else begin
            ns = IDLE;
            nd = NONE;
          end
        end
      end
      default: begin
        ns = IDLE;
        nd = NONE;
      end
    endcase
    if (ns != state) tclr = 1'b1;
  end

  // A call opposite to travel is taken when nothing lies further on.
  assign up_ok = (dir != DN) | (floor == BOT)
               | (!blw & !reqdn[floor]);
  assign dn_ok = (dir == DN) | (floor == TOP)
               | ((dir == UP) & !abv & !requp[floor])
               | ((dir == NONE) & !requp[floor]);

  assign wu = (state == DOOR) & requp[floor] & up_ok;
  assign wd = (state == DOOR) & reqdn[floor] & dn_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pu <= 1'b0;
      pd <= 1'b0;
    end else if (frz) begin
      pu <= 1'b0;
      pd <= 1'b0;
    end else begin
      pu <= wu & ~pu;
      pd <= wd & ~pd;
    end
  end

  always_comb begin
    clrup     = '0;
    clrdn     = '0;
    if (pu && !frz) clrup[floor] = 1'b1;
    if (pd && !frz) clrdn[floor] = 1'b1;
    upsig     = (state != IDLE) && (dir == UP);
    dnsig     = (state != IDLE) && (dir == DN);
    moving    = ((state == MOVE_UP) || (state == MOVE_DN)) && !frz;
    door_open = (state == DOOR);
  end

endmodule
